// File: rtl/nor_unit_rr_arbiter.sv
// nor_unit_rr_arbiter
// Round-robin arbiter and 3-cycle sequencer that shares one registered
// bitwise NOR unit (y = ~(a | b)) among NREQ requesters. A request accepted
// in IDLE is granted, executed and answered in three cycles. The answer is
// tagged with the index of the requester that owns it.

module nor_unit_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        y,
  output logic                    y_valid,
  output logic [IDW-1:0]          y_id,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [IDW-1:0]   ptr_reg, ptr_next;
  logic [WIDTH-1:0] a_lat_reg, a_lat_next;
  logic [WIDTH-1:0] b_lat_reg, b_lat_next;
  logic [NREQ-1:0]  gnt_reg, gnt_next;
  logic [WIDTH-1:0] y_reg, y_next;
  logic             y_valid_reg, y_valid_next;
  logic [IDW-1:0]   y_id_reg, y_id_next;

  // Unpacked views of the per-requester operand slices.
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = a_in[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = b_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Winner search: the first set req bit at or after ptr, wrapping to 0.
  logic [IDW-1:0] win;
  logic [IDW:0]   cand;
  logic           found;

  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_reg} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!found && req[cand[IDW-1:0]]) begin
        win   = cand[IDW-1:0];
        found = 1'b1;
      end
    end
  end

  // Next-state and next-output logic for the grant/execute/respond sequence.
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    a_lat_next   = a_lat_reg;
    b_lat_next   = b_lat_reg;
    gnt_next     = '0;
    y_next       = y_reg;
    y_valid_next = 1'b0;
    y_id_next    = y_id_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          a_lat_next = a_arr[win];
          b_lat_next = b_arr[win];
          gnt_next   = NREQ'(1) << win;
          y_id_next  = win;
          ptr_next   = (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        y_next       = ~(a_lat_reg | b_lat_reg);
        y_valid_next = 1'b1;
        state_next   = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      a_lat_reg   <= '0;
      b_lat_reg   <= '0;
      gnt_reg     <= '0;
      y_reg       <= '0;
      y_valid_reg <= 1'b0;
      y_id_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      a_lat_reg   <= a_lat_next;
      b_lat_reg   <= b_lat_next;
      gnt_reg     <= gnt_next;
      y_reg       <= y_next;
      y_valid_reg <= y_valid_next;
      y_id_reg    <= y_id_next;
    end
  end

  assign gnt     = gnt_reg;
  assign y       = y_reg;
  assign y_valid = y_valid_reg;
  assign y_id    = y_id_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_nor_unit_rr_arbiter.sv
// Testbench for nor_unit_rr_arbiter: directed and randomized transactions
// checked against a behavioural round-robin model.

module tb_nor_unit_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] a_in = '0;
  logic [NREQ*WIDTH-1:0] b_in = '0;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      y;
  logic                  y_valid;
  logic [IDW-1:0]        y_id;
  logic                  busy;

  nor_unit_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt     (gnt),
    .y       (y),
    .y_valid (y_valid),
    .y_id    (y_id),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: round-robin pointer and last delivered result.
  int         mptr    = 0;
  logic [7:0] last_y  = '0;
  int         last_id = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin choice: first requester at or after p, wrapping around.
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_y_valid", y_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_y", y, 0);
    check("rst_y_id", y_id, 0);
    step();
    step();
    rst = 1'b0;
    mptr    = 0;
    last_y  = '0;
    last_id = 0;
  endtask

  task automatic idle(input int n);
    req = '0;
    repeat (n) begin
      step();
      check("idle_gnt", gnt, 0);
      check("idle_busy", busy, 0);
      check("idle_y_valid", y_valid, 0);
      check("idle_y_hold", y, last_y);
      check("idle_id_hold", y_id, last_id);
    end
  endtask

  // mode 0: drop req after grant; 1: hold req; 2: random req noise in EXEC/RESP.
  task automatic run_txn(input logic [3:0] r, input logic [31:0] av,
                         input logic [31:0] bv, input int mode);
    int         w;
    logic [7:0] ey;
    req  = r;
    a_in = av;
    b_in = bv;
    w    = pick(r, mptr);
    ey   = ~(av[w*8 +: 8] | bv[w*8 +: 8]);
    step();
    check("gnt", gnt, 32'(1) << w);
    check("exec_busy", busy, 1);
    check("exec_y_valid", y_valid, 0);
    check("exec_y_id", y_id, w);
    a_in = $urandom;
    b_in = $urandom;
    if (mode == 0) req = r & ~(4'(1) << w);
    if (mode == 2) req = 4'($urandom);
    step();
    check("resp_y_valid", y_valid, 1);
    check("resp_y", y, ey);
    check("resp_y_id", y_id, w);
    check("resp_gnt", gnt, 0);
    check("resp_busy", busy, 1);
    a_in = $urandom;
    b_in = $urandom;
    if (mode == 2) req = 4'($urandom);
    step();
    check("end_y_valid", y_valid, 0);
    check("end_gnt", gnt, 0);
    check("end_busy", busy, 0);
    check("end_y_hold", y, ey);
    mptr    = (w + 1) % NREQ;
    last_y  = ey;
    last_id = w;
    $display("[TB] txn req=%b winner=%0d y=%h expected=%h", r, w, y, ey);
    if (mode == 2) begin
      req = '0;
      step();
      check("noise_ignored", gnt, 0);
      check("noise_busy", busy, 0);
    end
  endtask

  initial begin
    do_reset();

    // Directed operand cases; other slots carry junk to expose slicing errors.
    run_txn(4'b0010, 32'h1234F056, 32'h9ABC0FDE, 0);
    idle(2);
    run_txn(4'b0100, 32'h11A02233, 32'h44055566, 0);
    run_txn(4'b0100, 32'hFF00FFFF, 32'hFF00FFFF, 0);

    // Continuous all-request from reset: 0,1,2,3 spaced three cycles apart.
    req = 4'hF;
    do_reset();
    repeat (4) run_txn(4'hF, $urandom, $urandom, 1);
    // ptr wrapped to 0: 1001 grants 0 then 3.
    run_txn(4'b1001, $urandom, $urandom, 0);
    run_txn(4'b1001, $urandom, $urandom, 0);
    // ptr=1 with 1001 grants 3 before 0.
    run_txn(4'b0001, $urandom, $urandom, 0);
    run_txn(4'b1001, $urandom, $urandom, 0);
    run_txn(4'b1001, $urandom, $urandom, 0);

    // Abort mid-EXEC after a grant to 1 (DUT ptr would be 2).
    idle(1);
    req = 4'b0010;
    step();
    check("pre_abort_gnt", gnt, 4'b0010);
    req = '0;
    do_reset();
    check("no_resp_after_abort", y_valid, 0);
    run_txn(4'b1001, $urandom, $urandom, 0);

    // Requests arriving during EXEC/RESP are ignored.
    repeat (3) run_txn(4'($urandom_range(1, 15)), $urandom, $urandom, 2);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      run_txn(4'($urandom_range(1, 15)), $urandom, $urandom, int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
